el2_bht_wr_sched: RTL and testbench

Write-port scheduler for the branch history table (BHT) counter array. It owns the array's single write port and shares it between three sources: a power-up/flush initialisation walk, mispredict-recovery writes, and buffered branch-resolution updates. Indices arrive already hashed by the BTB/GHR hash logic. The scheduler sits between the EXU/decode update paths and the BHT RAM or flop array.

---
 rtl/el2_bht_wr_sched.sv | 155 +++++++++++++++
 tb/tb_el2_bht_wr_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/el2_bht_wr_sched.sv
// Write-port scheduler for the BHT counter array: arbitrates between the
// init walk, mispredict-recovery writes and a buffered update FIFO.
module el2_bht_wr_sched #(
  parameter int BHT_ADDR_W = 8,
  parameter int DATA_W = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  input  logic                  mp_valid,
  input  logic [BHT_ADDR_W-1:0] mp_index,
  input  logic [DATA_W-1:0]     mp_data,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [BHT_ADDR_W-1:0] upd_index,
  input  logic [DATA_W-1:0]     upd_data,
  output logic                  wr_en,
  output logic [BHT_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  init_busy,
  output logic                  mp_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_n;
  logic [BHT_ADDR_W-1:0]   icnt, icnt_n;

  logic [BHT_ADDR_W-1:0]   fifo_idx  [FIFO_DEPTH];
  logic [DATA_W-1:0]       fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_vld, fifo_vld_n, inval;
  logic [PTR_W-1:0]        wptr, rptr;
  logic [CNT_W-1:0]        count;
  logic                    full, empty;

  logic                    sel_en;
  logic [BHT_ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]       sel_data;
  logic                    drop, pop, push, flush, head_stale;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign upd_ready = (state == RUN) && !full;
  assign init_busy = (state == INIT);
  assign push      = upd_valid && upd_ready && !flush;

  // A head entry is stale if an earlier mispredict hit it, or this one does.
  assign head_stale = !fifo_vld[rptr] || (mp_valid && (fifo_idx[rptr] == mp_index));

  always_comb begin
    state_n  = state;
    icnt_n   = icnt;
    sel_en   = 1'b0;
    sel_addr = icnt;
    sel_data = INIT_VAL;
    drop     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    inval    = '0;
    case (state)
      INIT: begin
        sel_en = 1'b1;
        icnt_n = icnt + BHT_ADDR_W'(1);
        drop   = mp_valid;
        if (init_req) begin
          icnt_n = '0;
        end else if (icnt == '1) begin
          state_n = RUN;
        end
      end
      default: begin
        if (init_req) begin
          state_n = INIT;
          icnt_n  = '0;
          flush   = 1'b1;
          drop    = mp_valid;
        end else begin
          if (mp_valid) begin
            sel_en   = 1'b1;
            sel_addr = mp_index;
            sel_data = mp_data;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
              inval[i] = fifo_vld[i] && (fifo_idx[i] == mp_index);
            end
          end
          if (!empty) begin
            if (head_stale) begin
              pop = 1'b1;
            end else if (!mp_valid) begin
              pop      = 1'b1;
              sel_en   = 1'b1;
              sel_addr = fifo_idx[rptr];
              sel_data = fifo_data[rptr];
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    fifo_vld_n = fifo_vld & ~inval;
    if (pop)  fifo_vld_n[rptr] = 1'b0;
    if (push) fifo_vld_n[wptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      icnt     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fifo_vld <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mp_drop  <= 1'b0;
    end else begin
      state   <= state_n;
      icnt    <= icnt_n;
      mp_drop <= drop;
      wr_en   <= sel_en;
      if (sel_en) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
        fifo_vld <= '0;
      end else begin
        fifo_vld <= fifo_vld_n;
        count    <= count + CNT_W'(push) - CNT_W'(pop);
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Payload storage carries no reset; occupancy and valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wptr]  <= upd_index;
      fifo_data[wptr] <= upd_data;
    end
  end

endmodule

// File: tb/tb_el2_bht_wr_sched.sv
// Scoreboard bench for el2_bht_wr_sched: expected writes are queued by the
// stimulus thread and checked by a negedge monitor on wr_en.
module tb_el2_bht_wr_sched;

  localparam int AW = 8;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_req = 1'b0;
  logic          mp_valid = 1'b0;
  logic [AW-1:0] mp_index = '0;
  logic [DW-1:0] mp_data = '0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [AW-1:0] upd_index = '0;
  logic [DW-1:0] upd_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          init_busy;
  logic          mp_drop;

  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q[$];

  el2_bht_wr_sched dut (
    .clk(clk), .rst(rst), .init_req(init_req),
    .mp_valid(mp_valid), .mp_index(mp_index), .mp_data(mp_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_data(upd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(init_busy), .mp_drop(mp_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, required no write", wr_addr, wr_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_seq: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   wr_addr, wr_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic exp_walk();
    for (int i = 0; i < (1 << AW); i++) exp_wr(AW'(i), 2'b01);
  endtask

  initial begin
    // Reset state
    step(); step(); step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_init_busy", 32'(init_busy), 1);
    chk("rst_upd_ready", 32'(upd_ready), 0);
    chk("rst_mp_drop", 32'(mp_drop), 0);

    // Initialisation walk after reset release (cycle 0 now)
    rst = 1'b0;
    exp_walk();
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k == 255 || k == 256) begin
        chk("walk_init_busy", 32'(init_busy), (k < 256) ? 1 : 0);
        chk("walk_upd_ready", 32'(upd_ready), (k < 256) ? 0 : 1);
      end
    end
    step();
    chk("walk_done_q", 32'(exp_q.size()), 0);

    // Single update, two-cycle latency
    upd_valid = 1'b1; upd_index = 8'h12; upd_data = 2'd3;
    chk("upd_ready_t", 32'(upd_ready), 1);
    exp_wr(8'h12, 2'd3);
    step();
    upd_valid = 1'b0;
    chk("upd_ready_t1", 32'(upd_ready), 1);
    chk("upd_wr_en_t1", 32'(wr_en), 0);
    step();
    chk("upd_wr_en_t2", 32'(wr_en), 1);
    chk("upd_wr_addr_t2", 32'(wr_addr), 32'h12);
    step();

    // Fill FIFO behind 5 back-to-back mispredicts
    for (int i = 0; i < 5; i++) exp_wr(AW'(8'h40 + i), DW'(i));
    for (int i = 0; i < 4; i++) exp_wr(AW'(8'h10 + i), DW'(3 - i));
    for (int i = 0; i < 5; i++) begin
      mp_valid = 1'b1; mp_index = AW'(8'h40 + i); mp_data = DW'(i);
      upd_valid = (i < 4); upd_index = AW'(8'h10 + i); upd_data = DW'(3 - i);
      chk("fill_upd_ready", 32'(upd_ready), (i < 4) ? 1 : 0);
      step();
    end
    mp_valid = 1'b0; upd_valid = 1'b0;
    chk("fill_wr_en_mp4", 32'(wr_en), 1);
    chk("fill_ready_full", 32'(upd_ready), 0);
    step();
    chk("drain_ready", 32'(upd_ready), 1);
    for (int j = 0; j < 4; j++) begin
      chk("drain_wr_en", 32'(wr_en), 1);
      step();
    end
    chk("drain_idle", 32'(wr_en), 0);
    chk("drain_q", 32'(exp_q.size()), 0);

    // Mispredict invalidates a stale queued entry
    exp_wr(8'h30, 2'd1); exp_wr(8'h31, 2'd2); exp_wr(8'h05, 2'd0); exp_wr(8'h09, 2'd2);
    mp_valid = 1'b1; mp_index = 8'h30; mp_data = 2'd1;
    upd_valid = 1'b1; upd_index = 8'h05; upd_data = 2'd3;
    step();
    mp_index = 8'h31; mp_data = 2'd2;
    upd_index = 8'h09; upd_data = 2'd2;
    step();
    mp_index = 8'h05; mp_data = 2'd0; upd_valid = 1'b0;
    step();
    mp_valid = 1'b0;
    step(); step(); step();
    chk("inval_idle", 32'(wr_en), 0);
    chk("inval_q", 32'(exp_q.size()), 0);

    // init_req with 3 pending entries and a colliding mispredict
    exp_wr(8'h50, 2'd1); exp_wr(8'h51, 2'd2); exp_wr(8'h52, 2'd3);
    exp_walk();
    for (int i = 0; i < 3; i++) begin
      mp_valid = 1'b1; mp_index = AW'(8'h50 + i); mp_data = DW'(i + 1);
      upd_valid = 1'b1; upd_index = AW'(8'h20 + i); upd_data = DW'(i + 1);
      step();
    end
    upd_valid = 1'b0; init_req = 1'b1; mp_index = 8'h53; mp_data = 2'd0;
    step();
    init_req = 1'b0; mp_valid = 1'b0;
    chk("flush_mp_drop", 32'(mp_drop), 1);
    chk("flush_wr_en", 32'(wr_en), 0);
    chk("flush_hold_addr", 32'(wr_addr), 32'h52);
    chk("flush_hold_data", 32'(wr_data), 3);
    chk("flush_init_busy", 32'(init_busy), 1);
    chk("flush_upd_ready", 32'(upd_ready), 0);
    step();
    chk("flush_drop_clear", 32'(mp_drop), 0);
    // cycle 5 after init_req; mispredict during the walk
    for (int c = 5; c <= 262; c++) begin
      mp_valid = (c == 10); mp_index = 8'h77; mp_data = 2'd2;
      if (c == 11) chk("walk_mp_drop", 32'(mp_drop), 1);
      if (c == 12) chk("walk_mp_drop_clr", 32'(mp_drop), 0);
      if (c == 259) chk("rewalk_busy_hi", 32'(init_busy), 1);
      if (c == 260) chk("rewalk_busy_lo", 32'(init_busy), 0);
      step();
    end
    mp_valid = 1'b0;
    chk("rewalk_q", 32'(exp_q.size()), 0);

    // Reset mid-walk at icnt=5
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_wr(AW'(i), 2'b01);
    for (int c = 1; c <= 5; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_init_busy", 32'(init_busy), 1);
    chk("midrst_q", 32'(exp_q.size()), 0);
    exp_walk();
    for (int c = 0; c < 260; c++) step();
    chk("midrst_walk_q", 32'(exp_q.size()), 0);
    chk("midrst_upd_ready", 32'(upd_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
